fu_result_router: RTL and testbench
===================================

Name: fu_result_router

Overview:
- Downstream stage of the tile adder functional unit.
- Captures each completed result word set (all lanes), together with its 4-bit destination mask, when the FU pulses its acknowledge.
- Buffers captured sets in a small FIFO and drives them to neighbour tiles (N/E/S/W) over per-direction valid/ready links.
- Supports multicast, and exerts backpressure to the FU's on/off control via a full flag.

Parameters:
- WIDTH, 16, bits per lane.
- NUM_LANES, 4, result lanes per entry.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- NUM_DIRS, 4, neighbour directions; fixed at 4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fu_result  in  [WIDTH-1:0] x NUM_LANES  FU result lanes.
- fu_dest  in  4  destination mask; bit0 N, bit1 E, bit2 S, bit3 W.
- fu_ack  in  1  single-cycle pulse; result and dest valid this cycle.
- fu_full  out  1  FIFO full; FU controller deasserts on_off while high.
- out_data  out  [WIDTH-1:0] x NUM_LANES x NUM_DIRS  per-direction lane data.
- out_valid  out  NUM_DIRS  per-direction valid.
- out_ready  in  NUM_DIRS  per-direction ready from neighbour.
- overflow  out  1  sticky; an ack arrived while full.
- empty  out  1  FIFO empty.

Behaviour:
- Reset:
  - FIFO pointers and count cleared; pending mask cleared.
  - out_valid=0, out_data=0, fu_full=0, overflow=0, empty=1.
  - Reset mid-transfer discards all entries with no partial delivery.
- Enqueue:
  - On fu_ack with !fu_full and fu_dest≠0, write {fu_dest, fu_result} at the write pointer.
  - Pointer wraps modulo DEPTH.
  - fu_ack with fu_dest=0 is discarded silently; not an overflow.
  - fu_ack while fu_full: data dropped, overflow set, held until reset.
- Full condition:
  - fu_full is registered count==DEPTH.
  - No same-cycle bypass: a push when full is refused even if the head retires that cycle.
- Latency: fu_ack in cycle N into an empty FIFO gives out_valid in cycle N+1.
- Head state:
  - pending[3:0] holds the head's undelivered directions.
  - Loaded from the head entry's mask whenever a new head becomes visible.
- Output drive:
  - out_valid[d] = !empty && pending[d].
  - out_data[d] = head lanes for every d; held stable while any out_valid is high.
- Transfer:
  - A transfer on d occurs on out_valid[d] && out_ready[d]; clears pending[d] next cycle.
  - Multiple directions may transfer in the same cycle.
- Retire:
  - When every remaining pending bit transfers in the current cycle, the head pops.
  - pending loads the next entry's mask in the same edge, giving back-to-back retire at 1 entry/cycle.
- Ordering: entries are delivered in FIFO order per direction. A blocked direction stalls the whole queue (head-of-line; accepted).
- Simultaneous push and pop with count<DEPTH: both occur; count unchanged.
- Push into empty plus pop: not possible, since empty has no head.

Optional Feature:
- Macro ROUTER_STATS_EN.
- Defined:
  - Adds output retired_cnt[15:0], incremented on each head pop.
  - Adds output drop_cnt[15:0], incremented on each overflowed ack.
  - Both counters wrap at 16'hFFFF→0 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fu_router_pkg:
  - Direction index constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3.
  - typedef dest_mask_t (logic [3:0]).
  - typedef router_entry_t struct {dest_mask_t dest; lane data array}.
- Sub-module router_fifo: a generic synchronous FIFO of router_entry_t with push, pop, full, empty, count and head output.
  - The pending/multicast retire logic stays in the top.

Test Plan:
1. Unicast:
   - Stimulus: reset, then fu_ack with dest=4'b0010 and lanes {1,2,3,4}; out_ready=4'b1111.
   - Response: cycle+1 out_valid=4'b0010, data {1,2,3,4}; cycle+2 empty=1.
2. Multicast, staggered ready:
   - Stimulus: dest=4'b1001; out_ready[0]=1, out_ready[3]=0 for 3 cycles, then 1.
   - Response: N transfers first; W valid stays high with stable data; entry retires only after W transfers.
3. Fill and overflow:
   - Stimulus: out_ready=0, 5 acks with lanes 10..14.
   - Response: fu_full=1 after the 4th; 5th dropped; overflow=1.
   - Then ready=1: words 10,11,12,13 emerge in order, one per cycle.
4. Zero-mask ack:
   - Stimulus: fu_ack with dest=0.
   - Response: empty stays 1; overflow stays 0.
5. Back-to-back:
   - Stimulus: acks every cycle (8 entries), all ready high.
   - Response: one retire per cycle; fu_full never asserts; FIFO order preserved across pointer wrap.
6. Reset mid-operation:
   - Stimulus: 3 queued entries, one direction blocked; assert reset.
   - Response: next cycle out_valid=0, empty=1, overflow=0 (counters 0 if ROUTER_STATS_EN).

Source files
------------

// File: rtl/fu_router_pkg.sv
// rtl/fu_router_pkg.sv - shared direction constants and entry types for the FU result router
package fu_router_pkg;

  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  localparam int LANE_W  = 16;
  localparam int N_LANES = 4;

  typedef logic [3:0] dest_mask_t;

  typedef struct packed {
    dest_mask_t                     dest;
    logic [N_LANES-1:0][LANE_W-1:0] data;
  } router_entry_t;

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - generic synchronous FIFO of router entries
// Push is ignored while full and pop while empty; DEPTH must be a power of two.
module router_fifo
  import fu_router_pkg::*;
#(
  parameter type entry_t = router_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  output entry_t                   o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; consumers must qualify the head with o_empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fu_result_router.sv
// rtl/fu_result_router.sv - buffers FU result sets and multicasts them to N/E/S/W neighbours
// Optional ROUTER_STATS_EN adds retired_cnt/drop_cnt statistics outputs.
module fu_result_router
  import fu_router_pkg::*;
#(
  parameter int WIDTH     = LANE_W,
  parameter int NUM_LANES = N_LANES,
  parameter int DEPTH     = 4,
  parameter int NUM_DIRS  = DIR_W + 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]            fu_result,
  input  logic [3:0]                                 fu_dest,
  input  logic                                       fu_ack,
  output logic                                       fu_full,
  output logic [NUM_DIRS-1:0][NUM_LANES-1:0][WIDTH-1:0] out_data,
  output logic [NUM_DIRS-1:0]                        out_valid,
  input  logic [NUM_DIRS-1:0]                        out_ready,
  output logic                                       overflow,
  output logic                                       empty
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0]                                retired_cnt,
  output logic [15:0]                                drop_cnt
`endif
);

  typedef struct packed {
    dest_mask_t                     dest;
    logic [NUM_LANES-1:0][WIDTH-1:0] data;
  } entry_t;

  entry_t                  w_wr_entry;
  entry_t                  w_head;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_unused_count;
  logic [NUM_DIRS-1:0]     r_done;
  logic [NUM_DIRS-1:0]     w_pending;
  logic [NUM_DIRS-1:0]     w_xfer;

  assign w_wr_entry     = {fu_dest, fu_result};
  assign w_push         = fu_ack && !w_fifo_full && (fu_dest != '0);
  assign w_unused_count = ^w_count;

  router_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  // Pending is the head's mask minus directions already delivered; clearing
  // r_done on pop makes the next head's full mask visible on the same edge.
  assign w_pending = w_head.dest & ~r_done;
  assign out_valid = w_fifo_empty ? '0 : w_pending;
  assign w_xfer    = out_valid & out_ready;
  assign w_pop     = !w_fifo_empty && ((w_pending & ~w_xfer) == '0);

  always_ff @(posedge clk) begin
    if (reset || w_pop) r_done <= '0;
    else                r_done <= r_done | w_xfer;
  end

  always_ff @(posedge clk) begin
    if (reset)                       overflow <= 1'b0;
    else if (fu_ack && w_fifo_full)  overflow <= 1'b1;
  end

  always_comb begin
    for (int d = 0; d < NUM_DIRS; d++) begin
      out_data[d] = w_fifo_empty ? '0 : w_head.data;
    end
  end

  assign fu_full = w_fifo_full;
  assign empty   = w_fifo_empty;

`ifdef ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (w_pop)                  retired_cnt <= retired_cnt + 16'd1;
      if (fu_ack && w_fifo_full)  drop_cnt    <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_result_router.sv
// tb/tb_fu_result_router.sv - randomized and directed bench against a queue-based reference model
module tb_fu_result_router;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int ND = 4;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [L-1:0][W-1:0]          fu_result;
  logic [3:0]                   fu_dest;
  logic                         fu_ack;
  logic                         fu_full;
  logic [ND-1:0][L-1:0][W-1:0]  out_data;
  logic [ND-1:0]                out_valid;
  logic [ND-1:0]                out_ready;
  logic                         overflow;
  logic                         empty;
`ifdef ROUTER_STATS_EN
  logic [15:0]                  retired_cnt;
  logic [15:0]                  drop_cnt;
`endif

  fu_result_router #(
    .WIDTH     (W),
    .NUM_LANES (L),
    .DEPTH     (D),
    .NUM_DIRS  (ND)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fu_result (fu_result),
    .fu_dest   (fu_dest),
    .fu_ack    (fu_ack),
    .fu_full   (fu_full),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .empty     (empty)
`ifdef ROUTER_STATS_EN
    ,
    .retired_cnt (retired_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Each queued entry carries its still-undelivered directions.
  typedef struct {
    logic [3:0]     remain;
    logic [L*W-1:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_ovf;
  int unsigned m_ret;
  int unsigned m_drop;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [L*W-1:0] mk(input int a, input int b, input int c, input int d);
    logic [15:0] la, lb, lc, ld;
    la = a[15:0]; lb = b[15:0]; lc = c[15:0]; ld = d[15:0];
    return {ld, lc, lb, la};
  endfunction

  task automatic step(input bit ack, input logic [3:0] dest, input logic [L*W-1:0] lanes,
                      input logic [3:0] rdy, input bit rst);
    logic [3:0]     ev;
    logic [L*W-1:0] ed;
    bit             was_full;
    reset     = rst;
    fu_ack    = ack;
    fu_dest   = dest;
    fu_result = lanes;
    out_ready = rdy;
    @(negedge clk);
    ev = (q.size() > 0) ? q[0].remain : 4'b0;
    ed = (q.size() > 0) ? q[0].data : '0;
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, {ND{ed}});
    chk("fu_full", fu_full, q.size() == D);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, m_ovf);
`ifdef ROUTER_STATS_EN
    chk("retired_cnt", retired_cnt, m_ret[15:0]);
    chk("drop_cnt", drop_cnt, m_drop[15:0]);
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_ret  = 0;
      m_drop = 0;
    end else begin
      was_full = (q.size() == D);
      if (q.size() > 0) begin
        q[0].remain = q[0].remain & ~rdy;
        if (q[0].remain == 4'b0) begin
          void'(q.pop_front());
          m_ret++;
        end
      end
      if (ack) begin
        if (was_full) begin
          m_ovf = 1'b1;
          m_drop++;
        end else if (dest != 4'b0) begin
          q.push_back('{remain: dest, data: lanes});
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_ovf = 0; m_ret = 0; m_drop = 0;
    reset = 1'b1; fu_ack = 1'b0; fu_dest = '0; fu_result = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;

    // unicast to E
    step(1'b1, 4'b0010, mk(1, 2, 3, 4), 4'b1111, 1'b0);
    idle(4'b1111, 3);

    // multicast N+W with W stalled for 3 cycles
    step(1'b1, 4'b1001, mk(5, 6, 7, 8), 4'b0001, 1'b0);
    idle(4'b0001, 3);
    idle(4'b1001, 2);

    // fill, overflow, then drain in order
    for (int v = 10; v <= 14; v++) step(1'b1, 4'b1111, mk(v, v, v, v), 4'b0000, 1'b0);
    idle(4'b0000, 1);
    idle(4'b1111, 6);

    // zero-mask ack is ignored
    step(1'b1, 4'b0000, mk(9, 9, 9, 9), 4'b1111, 1'b0);
    idle(4'b1111, 1);

    // reset clears sticky overflow, then back-to-back traffic across pointer wrap
    step(1'b0, 4'b0, '0, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'($urandom_range(1, 15)), mk(100 + i, i, 200 + i, i * 3), 4'b1111, 1'b0);
    idle(4'b1111, 3);

    // reset mid-operation with N blocked
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0011, mk(50 + i, 0, 0, 1), 4'b0000, 1'b0);
    idle(4'b1110, 2);
    step(1'b0, 4'b0, '0, 4'b1110, 1'b1);
    idle(4'b1111, 2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] dst;
      dst = ($urandom_range(0, 9) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      step(1'($urandom_range(0, 1)), dst, {$urandom, $urandom},
           4'($urandom_range(0, 15)) | 4'($urandom_range(0, 1) ? 15 : 0),
           $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
